// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the program-memory port arbiter: window defaults,
// response-owner encoding and the window check.
package imem_pkg;

  localparam logic [31:0] BASE_ADDR_DEF  = 32'hBFC0_0000;
  localparam int unsigned MEM_AW_DEF     = 12;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic [2:0] {
    RESP_NONE,
    RESP_IF_RD,
    RESP_IF_ERR,
    RESP_D_RD,
    RESP_D_WR,
    RESP_D_ERR
  } resp_owner_t;

  // Offset already rebased to the window; addresses below the base wrap high and fail.
  function automatic logic in_window(input logic [31:0] offset, input int unsigned aw);
    return (offset >> aw) == 32'd0;
  endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the program-memory arbiter.
interface imem_port_arbiter_if #(
  parameter int unsigned MEM_AW = 12
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              if_err;

  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/imem_port_arbiter_addr_xlate.sv
// CPU address to word-aligned memory offset, with window and optional alignment check.
module imem_addr_xlate
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter int unsigned MEM_AW      = MEM_AW_DEF,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic [31:0]       i_addr,
  output logic [MEM_AW-1:0] o_offset,
  output logic              o_err
);

  logic [31:0] w_off;
  logic        w_in_win;
  logic        w_misalign;

  assign w_off      = i_addr - BASE_ADDR;
  assign w_in_win   = in_window(w_off, MEM_AW);
  assign w_misalign = CHECK_ALIGN && (i_addr[1:0] != 2'b00);
  assign o_offset   = {w_off[MEM_AW-1:2], 2'b00};
  assign o_err      = !w_in_win || w_misalign;

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port program memory between instruction fetch and a data port,
// one access per cycle, with a registered response owner covering the read latency.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF,
  parameter int unsigned MEM_AW     = MEM_AW_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input logic                clk,
  input logic                rst_n,
  imem_port_arbiter_if.slave bus
);

  localparam int unsigned         CW         = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]       STARVE_LIM = CW'(STARVE_MAX);

  resp_owner_t       r_owner;
  resp_owner_t       w_next_owner;
  logic [CW-1:0]     r_starve_cnt;

  logic [MEM_AW-1:0] w_if_off;
  logic [MEM_AW-1:0] w_d_off;
  logic              w_if_err;
  logic              w_d_err;
  logic              w_starved;
  logic              w_sel_if;
  logic              w_sel_d;

  imem_addr_xlate #(
    .BASE_ADDR   (BASE_ADDR),
    .MEM_AW      (MEM_AW),
    .CHECK_ALIGN (1'b1)
  ) u_if_xlate (
    .i_addr   (bus.if_addr),
    .o_offset (w_if_off),
    .o_err    (w_if_err)
  );

  imem_addr_xlate #(
    .BASE_ADDR   (BASE_ADDR),
    .MEM_AW      (MEM_AW),
    .CHECK_ALIGN (1'b0)
  ) u_d_xlate (
    .i_addr   (bus.d_addr),
    .o_offset (w_d_off),
    .o_err    (w_d_err)
  );

  // Grants are held off during reset so nothing is accepted whose response would be dropped.
  assign w_starved = (r_starve_cnt == STARVE_LIM);
  assign w_sel_if  = rst_n && bus.if_req && (!bus.d_req || w_starved);
  assign w_sel_d   = rst_n && bus.d_req && !w_sel_if;

  always_comb begin
    w_next_owner  = RESP_NONE;
    bus.if_gnt    = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    if (w_sel_if) begin
      bus.if_gnt = 1'b1;
      if (w_if_err) begin
        w_next_owner = RESP_IF_ERR;
      end else begin
        w_next_owner = RESP_IF_RD;
        bus.mem_en   = 1'b1;
        bus.mem_addr = w_if_off;
      end
    end else if (w_sel_d) begin
      bus.d_gnt = 1'b1;
      if (w_d_err) begin
        w_next_owner = RESP_D_ERR;
      end else begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = w_d_off;
        if (bus.d_we) begin
          w_next_owner  = RESP_D_WR;
          bus.mem_we    = 1'b1;
          bus.mem_wdata = bus.d_wdata;
          bus.mem_be    = bus.d_be;
        end else begin
          w_next_owner = RESP_D_RD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner      <= RESP_NONE;
      r_starve_cnt <= '0;
    end else begin
      r_owner <= w_next_owner;
      if (bus.if_req && !bus.if_gnt) begin
        if (!w_starved) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

  always_comb begin
    bus.if_rvalid = 1'b0;
    bus.if_err    = 1'b0;
    bus.if_rdata  = '0;
    bus.d_rvalid  = 1'b0;
    bus.d_err     = 1'b0;
    bus.d_rdata   = '0;
    unique case (r_owner)
      RESP_IF_RD: begin
        bus.if_rvalid = 1'b1;
        bus.if_rdata  = bus.mem_rdata;
      end
      RESP_IF_ERR: begin
        bus.if_rvalid = 1'b1;
        bus.if_err    = 1'b1;
      end
      RESP_D_RD: begin
        bus.d_rvalid = 1'b1;
        bus.d_rdata  = bus.mem_rdata;
      end
      RESP_D_WR: begin
        bus.d_rvalid = 1'b1;
      end
      RESP_D_ERR: begin
        bus.d_rvalid = 1'b1;
        bus.d_err    = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: byte-array memory emulation plus a cycle-level
// reference model of arbitration, starvation and responses.
module tb_imem_port_arbiter;
  import imem_pkg::*;

  localparam logic [31:0] BASE = 32'hBFC0_0000;
  localparam int          SMAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_port_arbiter_if #(.MEM_AW(12)) bus();

  imem_port_arbiter #(
    .BASE_ADDR  (BASE),
    .MEM_AW     (12),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem_b   [0:4095];
  logic [7:0] ref_mem [0:4095];

  // Memory emulation: one-cycle read latency, garbage on rdata when not reading.
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      for (int k = 0; k < 4; k++)
        if (bus.mem_be[k]) mem_b[(int'(bus.mem_addr) + k) & 4095] <= bus.mem_wdata[8*k +: 8];
    end
    if (bus.mem_en && !bus.mem_we)
      bus.mem_rdata <= {mem_b[int'(bus.mem_addr) + 3], mem_b[int'(bus.mem_addr) + 2],
                        mem_b[int'(bus.mem_addr) + 1], mem_b[int'(bus.mem_addr)]};
    else
      bus.mem_rdata <= $urandom();
  end

  typedef struct packed {
    logic        v;
    logic        err;
    logic [31:0] data;
  } resp_t;

  int          starve;
  bit          rel_rst;
  resp_t       p_if, p_d, e_if, e_d;
  logic        e_if_gnt, e_d_gnt, e_mem_en, e_mem_we;
  logic [11:0] e_mem_addr;
  logic [3:0]  e_mem_be;
  logic [31:0] e_mem_wdata;

  function automatic logic [31:0] ref_word(input logic [31:0] off);
    int a;
    a = int'(off[11:2]) * 4;
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  function automatic logic [31:0] rand_addr(input bit fetch);
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return ($urandom_range(0, 1) == 0) ? BASE - 32'd4 : BASE + 32'h1000 + {$urandom_range(0, 255), 2'b00};
    if (r == 1 && fetch) return BASE + {$urandom_range(0, 1023), 2'b00} + 32'($urandom_range(1, 3));
    return BASE + {$urandom_range(0, 1023), 2'b00} + (fetch ? 32'd0 : 32'($urandom_range(0, 3)));
  endfunction

  // Drive one cycle of requests at the falling edge and compute what the arbiter must do.
  task automatic cycle(input bit ireq, input logic [31:0] iaddr, input bit dreq, input bit dwe,
                       input logic [31:0] daddr, input logic [31:0] dwd, input logic [3:0] dbe);
    logic [31:0] off;
    bit fw, dw, bad;
    @(negedge clk);
    if (rel_rst) begin rst_n = 1'b1; rel_rst = 1'b0; end
    bus.if_req = ireq; bus.if_addr = iaddr;
    bus.d_req = dreq; bus.d_we = dwe; bus.d_addr = daddr; bus.d_wdata = dwd; bus.d_be = dbe;
    e_if = p_if; e_d = p_d; p_if = '0; p_d = '0;
    e_if_gnt = 0; e_d_gnt = 0; e_mem_en = 0; e_mem_we = 0;
    e_mem_addr = '0; e_mem_be = '0; e_mem_wdata = '0;
    fw = ireq && (!dreq || starve == SMAX);
    dw = dreq && !fw;
    if (fw) begin
      off = iaddr - BASE;
      bad = (off >= 32'd4096) || (iaddr[1:0] != 2'b00);
      e_if_gnt = 1; p_if.v = 1; p_if.err = bad;
      if (!bad) begin e_mem_en = 1; e_mem_addr = off[11:0] & 12'hFFC; p_if.data = ref_word(off); end
    end else if (dw) begin
      off = daddr - BASE;
      bad = off >= 32'd4096;
      e_d_gnt = 1; p_d.v = 1; p_d.err = bad;
      if (!bad) begin
        e_mem_en = 1; e_mem_addr = off[11:0] & 12'hFFC;
        if (dwe) begin
          e_mem_we = 1; e_mem_be = dbe; e_mem_wdata = dwd;
          for (int k = 0; k < 4; k++)
            if (dbe[k]) ref_mem[int'(off[11:2]) * 4 + k] = dwd[8*k +: 8];
        end else begin
          p_d.data = ref_word(off);
        end
      end
    end
    starve = (ireq && !fw) ? ((starve + 1 > SMAX) ? SMAX : starve + 1) : 0;
    #2;
  endtask

  task automatic idle();
    cycle(0, '0, 0, 0, '0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    starve = 0; p_if = '0; p_d = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.if_req = 0; bus.d_req = 0; bus.if_addr = '0; bus.d_addr = '0;
    bus.d_we = 0; bus.d_wdata = '0; bus.d_be = '0;
    repeat (2) @(negedge clk);
    #2;
    n_tests++; if ({bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=0000", {bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err}); end
    n_tests++; if (bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata got if=%h d=%h exp=0", bus.if_rdata, bus.d_rdata); end
    n_tests++; if (bus.mem_en !== 1'b0 || bus.mem_addr !== 12'h0) begin
      n_fail++; $display("FAIL reset_mem got en=%b addr=%h exp 0", bus.mem_en, bus.mem_addr); end
    rst_n = 1'b1;
    starve = 0; p_if = '0; p_d = '0;
  endtask

  task automatic test_fetch();
    cycle(1, 32'hBFC0_0008, 0, 0, '0, '0, '0);
    n_tests++; if (bus.if_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin
      n_fail++; $display("FAIL fetch_gnt got if=%b d=%b exp if=1 d=0", bus.if_gnt, bus.d_gnt); end
    n_tests++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 12'h008) begin
      n_fail++; $display("FAIL fetch_mem got en=%b we=%b addr=%h exp 1/0/008", bus.mem_en, bus.mem_we, bus.mem_addr); end
    idle();
    n_tests++; if (bus.if_rvalid !== 1'b1 || bus.if_err !== 1'b0 || bus.if_rdata !== 32'h0B0A_0908) begin
      n_fail++; $display("FAIL fetch_resp got v=%b e=%b d=%h exp 1/0/0b0a0908", bus.if_rvalid, bus.if_err, bus.if_rdata); end
    n_tests++; if (bus.d_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL fetch_dside got d_rvalid=%b exp 0", bus.d_rvalid); end
  endtask

  task automatic test_write();
    cycle(0, '0, 1, 1, 32'hBFC0_0010, 32'hDEAD_BEEF, 4'b0011);
    n_tests++; if (bus.d_gnt !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1) begin
      n_fail++; $display("FAIL write_strobe got gnt=%b en=%b we=%b exp 111", bus.d_gnt, bus.mem_en, bus.mem_we); end
    n_tests++; if (bus.mem_be !== 4'b0011 || bus.mem_addr !== 12'h010 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL write_bus got be=%b addr=%h wd=%h", bus.mem_be, bus.mem_addr, bus.mem_wdata); end
    cycle(1, 32'hBFC0_0010, 0, 0, '0, '0, '0);
    n_tests++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0 || bus.d_err !== 1'b0) begin
      n_fail++; $display("FAIL write_resp got v=%b d=%h e=%b exp 1/0/0", bus.d_rvalid, bus.d_rdata, bus.d_err); end
    idle();
    n_tests++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h1312_BEEF) begin
      n_fail++; $display("FAIL write_readback got v=%b d=%h exp 1/1312beef", bus.if_rvalid, bus.if_rdata); end
  endtask

  task automatic test_errors();
    cycle(1, 32'hBFC0_1000, 0, 0, '0, '0, '0);
    n_tests++; if (bus.if_gnt !== 1'b1 || bus.mem_en !== 1'b0 || bus.mem_addr !== 12'h0) begin
      n_fail++; $display("FAIL err_oow_grant got gnt=%b en=%b addr=%h exp 1/0/000", bus.if_gnt, bus.mem_en, bus.mem_addr); end
    cycle(1, 32'hBFC0_0002, 0, 0, '0, '0, '0);
    n_tests++; if (bus.if_rvalid !== 1'b1 || bus.if_err !== 1'b1 || bus.if_rdata !== 32'h0) begin
      n_fail++; $display("FAIL err_oow_resp got v=%b e=%b d=%h exp 1/1/0", bus.if_rvalid, bus.if_err, bus.if_rdata); end
    n_tests++; if (bus.if_gnt !== 1'b1 || bus.mem_en !== 1'b0) begin
      n_fail++; $display("FAIL err_misalign_grant got gnt=%b en=%b exp 1/0", bus.if_gnt, bus.mem_en); end
    cycle(0, '0, 1, 0, 32'hBFBF_FFFC, '0, 4'hF);
    n_tests++; if (bus.if_rvalid !== 1'b1 || bus.if_err !== 1'b1) begin
      n_fail++; $display("FAIL err_misalign_resp got v=%b e=%b exp 1/1", bus.if_rvalid, bus.if_err); end
    n_tests++; if (bus.d_gnt !== 1'b1 || bus.mem_en !== 1'b0) begin
      n_fail++; $display("FAIL err_d_grant got gnt=%b en=%b exp 1/0", bus.d_gnt, bus.mem_en); end
    cycle(1, 32'hBFC0_0FFC, 0, 0, '0, '0, '0);
    n_tests++; if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b1 || bus.d_rdata !== 32'h0) begin
      n_fail++; $display("FAIL err_d_resp got v=%b e=%b d=%h exp 1/1/0", bus.d_rvalid, bus.d_err, bus.d_rdata); end
    idle();
    n_tests++; if (bus.if_rvalid !== 1'b1 || bus.if_err !== 1'b0 || bus.if_rdata !== e_if.data) begin
      n_fail++; $display("FAIL err_top_word got v=%b e=%b d=%h exp 1/0/%h", bus.if_rvalid, bus.if_err, bus.if_rdata, e_if.data); end
  endtask

  task automatic test_contention();
    logic [31:0] da;
    da = rand_addr(0) & 32'hFFFF_FFFC | 32'hBFC0_0000;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 32'hBFC0_0020, 1, 0, BASE + {22'd0, 8'(i), 2'b00}, '0, 4'hF);
      n_tests++; if (bus.if_gnt !== ((i % 5) == 4) || bus.d_gnt !== ((i % 5) != 4)) begin
        n_fail++; $display("FAIL contention_c%0d got if=%b d=%b exp if=%b", i, bus.if_gnt, bus.d_gnt, (i % 5) == 4); end
      n_tests++; if (bus.d_rvalid !== e_d.v || bus.d_rdata !== e_d.data || bus.if_rvalid !== e_if.v) begin
        n_fail++; $display("FAIL contention_resp%0d got dv=%b dd=%h iv=%b exp %b/%h/%b", i, bus.d_rvalid, bus.d_rdata, bus.if_rvalid, e_d.v, e_d.data, e_if.v); end
    end
    idle();
    n_tests++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== e_if.data || da[1:0] !== 2'b00) begin
      n_fail++; $display("FAIL contention_last got v=%b d=%h exp 1/%h", bus.if_rvalid, bus.if_rdata, e_if.data); end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) cycle(1, 32'hBFC0_0040, 1, 0, 32'hBFC0_0080, '0, 4'hF);
    @(negedge clk);
    rst_n = 1'b0;
    bus.if_req = 0; bus.d_req = 0;
    @(negedge clk);
    #2;
    n_tests++; if ({bus.if_rvalid, bus.d_rvalid, bus.if_gnt, bus.d_gnt, bus.mem_en} !== 5'b0) begin
      n_fail++; $display("FAIL midrst_outputs got %b exp 00000", {bus.if_rvalid, bus.d_rvalid, bus.if_gnt, bus.d_gnt, bus.mem_en}); end
    n_tests++; if (bus.d_rdata !== 32'h0 || bus.d_err !== 1'b0) begin
      n_fail++; $display("FAIL midrst_rdata got d=%h e=%b exp 0/0", bus.d_rdata, bus.d_err); end
    starve = 0; p_if = '0; p_d = '0;
    rel_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 32'hBFC0_0040, 1, 0, 32'hBFC0_0080, '0, 4'hF);
      if (i == 0) begin
        n_tests++; if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
          n_fail++; $display("FAIL midrst_no_rvalid got if=%b d=%b exp 0/0", bus.if_rvalid, bus.d_rvalid); end
      end
      n_tests++; if (bus.if_gnt !== (i == 4) || bus.d_gnt !== (i != 4)) begin
        n_fail++; $display("FAIL midrst_starve_c%0d got if=%b d=%b exp if=%b", i, bus.if_gnt, bus.d_gnt, i == 4); end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    bit we;
    for (int i = 0; i < 9; i++) begin
      we = $urandom_range(0, 1) == 1;
      if (i == 8) idle();
      else if (i % 2 == 0) cycle(1, rand_addr(1), 0, 0, '0, '0, '0);
      else cycle(0, '0, 1, we, rand_addr(0), $urandom(), 4'($urandom_range(0, 15)));
      n_tests++; if (bus.if_gnt !== e_if_gnt || bus.d_gnt !== e_d_gnt) begin
        n_fail++; $display("FAIL b2b_gnt%0d got if=%b d=%b exp %b/%b", i, bus.if_gnt, bus.d_gnt, e_if_gnt, e_d_gnt); end
      n_tests++; if ({bus.if_rvalid, bus.if_err, bus.if_rdata} !== {e_if.v, e_if.err, e_if.data}
                  || {bus.d_rvalid, bus.d_err, bus.d_rdata} !== {e_d.v, e_d.err, e_d.data}
                  || (bus.if_rvalid && bus.d_rvalid)) begin
        n_fail++; $display("FAIL b2b_resp%0d got if=%b/%b/%h d=%b/%b/%h exp if=%b/%b/%h d=%b/%b/%h", i,
          bus.if_rvalid, bus.if_err, bus.if_rdata, bus.d_rvalid, bus.d_err, bus.d_rdata,
          e_if.v, e_if.err, e_if.data, e_d.v, e_d.err, e_d.data); end
    end
  endtask

  task automatic test_random();
    bit ireq, dreq, dwe;
    logic [31:0] ia, da, dwd;
    logic [3:0] dbe;
    ireq = 0; dreq = 0; dwe = 0; ia = '0; da = '0; dwd = '0; dbe = '0;
    for (int i = 0; i < 400; i++) begin
      if (!ireq && $urandom_range(0, 3) != 0) begin ireq = 1; ia = rand_addr(1); end
      if (!dreq && $urandom_range(0, 2) != 0) begin
        dreq = 1; da = rand_addr(0); dwe = $urandom_range(0, 1) == 1; dwd = $urandom(); dbe = 4'($urandom_range(0, 15));
      end
      cycle(ireq, ia, dreq, dwe, da, dwd, dbe);
      n_tests++; if ({bus.if_gnt, bus.d_gnt} !== {e_if_gnt, e_d_gnt}) begin
        n_fail++; $display("FAIL rnd_gnt%0d got %b%b exp %b%b", i, bus.if_gnt, bus.d_gnt, e_if_gnt, e_d_gnt); end
      n_tests++; if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata}
                  !== {e_mem_en, e_mem_we, e_mem_addr, e_mem_be, e_mem_wdata}) begin
        n_fail++; $display("FAIL rnd_mem%0d got en=%b we=%b a=%h be=%b wd=%h exp en=%b we=%b a=%h be=%b wd=%h", i,
          bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
          e_mem_en, e_mem_we, e_mem_addr, e_mem_be, e_mem_wdata); end
      n_tests++; if ({bus.if_rvalid, bus.if_err, bus.if_rdata} !== {e_if.v, e_if.err, e_if.data}) begin
        n_fail++; $display("FAIL rnd_if_resp%0d got %b/%b/%h exp %b/%b/%h", i,
          bus.if_rvalid, bus.if_err, bus.if_rdata, e_if.v, e_if.err, e_if.data); end
      n_tests++; if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {e_d.v, e_d.err, e_d.data}) begin
        n_fail++; $display("FAIL rnd_d_resp%0d got %b/%b/%h exp %b/%b/%h", i,
          bus.d_rvalid, bus.d_err, bus.d_rdata, e_d.v, e_d.err, e_d.data); end
      if (e_if_gnt) ireq = 0;
      if (e_d_gnt) dreq = 0;
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_b[i]   <= 8'(i);
      ref_mem[i] = 8'(i);
    end
    starve = 0; rel_rst = 0; p_if = '0; p_d = '0; e_if = '0; e_d = '0;
    test_reset();
    test_fetch();
    test_write();
    test_errors();
    test_contention();
    test_reset_midop();
    test_back_to_back();
    do_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
